// File: rtl/fifo_reader.sv
// fifo_reader: drains a standard-mode synchronous FIFO (one-cycle read
// latency) into a valid/ready stream with fixed-length packet framing.
// A 2-entry output buffer hides the read latency so one beat per cycle
// is sustained. Stop requests take effect only at packet boundaries.
//
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   enable             1 = run, 0 = stop at next packet boundary
//   fifo_dout          FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_empty         FIFO empty flag
//   fifo_rd_en         FIFO read strobe (combinational)
//   m_data/m_valid     stream payload / valid (registered)
//   m_last             last beat of a packet, qualified by m_valid
//   m_ready            downstream ready
//   busy               FSM active, read in flight, or buffer non-empty
//
// Optional build macro FIFO_READER_STATS_EN adds:
//   stat_beats (32b)   accepted beats, saturating
//   stat_pkts  (16b)   accepted last beats, wrapping
module fifo_reader #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]       stat_beats,
  output logic [15:0]       stat_pkts
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [1:0]        occ;
  logic              inflight;
  logic [DATA_W-1:0] buf_tail;
  logic              pop;
  logic              room;
  logic              issue_wrap;

  assign pop        = m_valid & m_ready;
  assign issue_wrap = (issue_cnt == LAST_IDX);
  // Buffer slots not yet claimed by held or in-flight words, after this cycle's pop
  assign room       = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign m_last     = m_valid & (out_cnt == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (enable) state_next = ST_RUN;
      ST_RUN:    if (!enable) state_next = (issue_cnt != '0) ? ST_FINISH : ST_IDLE;
      ST_FINISH: begin
        if (enable)                        state_next = ST_RUN;
        else if (fifo_rd_en && issue_wrap) state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic: read strobe and busy
  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = inflight | (occ != 2'd0);
    case (state)
      // A stop seen exactly at a boundary must not open a new packet
      ST_RUN: begin
        fifo_rd_en = (enable | (issue_cnt != '0)) & ~fifo_empty & room;
        busy       = 1'b1;
      end
      ST_FINISH: begin
        fifo_rd_en = ~fifo_empty & room;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, in-flight tracking and the 2-entry output buffer (head = m_data)
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      issue_cnt <= '0;
      out_cnt   <= '0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      buf_tail  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_en) issue_cnt <= issue_wrap ? '0 : issue_cnt + 16'd1;
      if (pop)        out_cnt   <= (out_cnt == LAST_IDX) ? '0 : out_cnt + 16'd1;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) m_data   <= fifo_dout;
          else             buf_tail <= fifo_dout;
          occ     <= occ + 2'd1;
          m_valid <= 1'b1;
        end
        2'b01: begin
          m_data  <= buf_tail;
          occ     <= occ - 2'd1;
          m_valid <= (occ == 2'd2);
        end
        // Capture and pop together: shift, keep occupancy
        2'b11: begin
          if (occ == 2'd1) begin
            m_data <= fifo_dout;
          end else begin
            m_data   <= buf_tail;
            buf_tail <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Accepted-beat and accepted-packet statistics
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else if (pop) begin
      if (stat_beats != 32'hFFFF_FFFF) stat_beats <= stat_beats + 32'd1;
      if (m_last)                      stat_pkts  <= stat_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader. A behavioural FIFO with one-cycle
// read latency feeds the DUT; accepted beats are collected and compared
// against the words pushed, in order, with m_last expected on every
// PKT_LEN-th beat since reset.
module tb_fifo_reader;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PKT_LEN = 16;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              enable;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic              busy;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]       stat_beats;
  logic [15:0]       stat_pkts;
`endif

  fifo_reader #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .enable     (enable),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .stat_beats (stat_beats),
    .stat_pkts  (stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wp = 0;
  int rp = 0;
  int illegal = 0;
  int rd_total = 0;
  bit flush = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] rx_d [$];
  logic       rx_l [$];
  int         rx_c [$];

  // Behavioural source FIFO
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) rp <= wp;
    else if (fifo_rd_en) begin
      if (wp == rp) illegal <= illegal + 1;
      else begin
        fifo_dout <= mem[rp % 256];
        rp <= rp + 1;
      end
    end
  end

  // Beat collector and read counter
  always @(negedge clk) begin
    if (arst_n && m_valid && m_ready) begin
      rx_d.push_back(m_data);
      rx_l.push_back(m_last);
      rx_c.push_back(cyc);
    end
    if (fifo_rd_en) rd_total <= rd_total + 1;
  end

  task automatic push_word(input logic [7:0] x);
    mem[wp % 256] = x;
    wp = wp + 1;
    exp_q.push_back(x);
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 400 && rx_d.size() < n; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    arst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete(); rx_d.delete(); rx_l.delete(); rx_c.delete();
    rd_total = 0;
    @(posedge clk); #1;
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, fifo_rd_en, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {m_valid, m_last, fifo_rd_en, busy});
    end
    checks++;
    if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
    // Mid-stream asynchronous reset
    do_reset();
    for (int i = 0; i < 24; i++) push_word(8'($urandom));
    enable = 1'b1; m_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy got %b want 1", busy); end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, fifo_rd_en, busy} !== 4'b0000) begin
      errors++; $display("FAIL midreset_async got %b want 0000", {m_valid, m_last, fifo_rd_en, busy});
    end
    @(posedge clk); #1;
    enable = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete(); rx_d.delete(); rx_l.delete(); rx_c.delete();
    arst_n = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    enable = 1'b1;
    wait_rx(16);
    checks++;
    if (rx_d.size() != 16) begin errors++; $display("FAIL postreset_count got %0d want 16", rx_d.size()); end
    for (int i = 0; i < 16 && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_q[i] || rx_l[i] !== ((i % PKT_LEN) == PKT_LEN - 1)) begin
        errors++;
        $display("FAIL postreset_beat[%0d] got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_q[i],
                 ((i % PKT_LEN) == PKT_LEN - 1));
      end
    end
  endtask

  task automatic test_streaming();
    logic rd_h [40];
    logic vl_h [40];
    int run;
    int first_v;
    do_reset();
    for (int i = 0; i < 32; i++) push_word(8'(i));
    enable = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL start_early got %b want 0", fifo_rd_en); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rd_h[i] = fifo_rd_en;
      vl_h[i] = m_valid;
    end
    run = 0;
    while (run < 40 && rd_h[run] === 1'b1) run++;
    checks++;
    if (run != 32) begin errors++; $display("FAIL stream_rd_run got %0d want 32", run); end
    first_v = -1;
    for (int i = 39; i >= 0; i--) if (vl_h[i] === 1'b1) first_v = i;
    checks++;
    if (first_v != 2) begin errors++; $display("FAIL stream_latency got %0d want 2", first_v); end
    wait_rx(32);
    checks++;
    if (rx_d.size() != 32) begin errors++; $display("FAIL stream_count got %0d want 32", rx_d.size()); end
    for (int i = 0; i < 32 && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_q[i] || rx_l[i] !== ((i % PKT_LEN) == PKT_LEN - 1)) begin
        errors++;
        $display("FAIL stream_beat[%0d] got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_q[i],
                 ((i % PKT_LEN) == PKT_LEN - 1));
      end
    end
    checks++;
    if (rx_c.size() != 32 || rx_c[31] - rx_c[0] != 31) begin
      errors++; $display("FAIL stream_gaps got span %0d want 31", rx_c.size() == 32 ? rx_c[31] - rx_c[0] : -1);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if (stat_beats !== 32'd32) begin errors++; $display("FAIL stat_beats got %0d want 32", stat_beats); end
    checks++;
    if (stat_pkts !== 16'd2) begin errors++; $display("FAIL stat_pkts got %0d want 2", stat_pkts); end
`endif
    enable = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_d;
    logic       held_l;
    do_reset();
    for (int i = 0; i < 32; i++) push_word(8'($urandom));
    enable = 1'b1; m_ready = 1'b1;
    wait_rx(8);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    held_d = m_data; held_l = m_last;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== held_d || m_last !== held_l) begin
        errors++; $display("FAIL bp_hold[%0d] got %b/%h/%b want 1/%h/%b", k, m_valid, m_data, m_last, held_d, held_l);
      end
      if (k > 0) begin
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en[%0d] got %b want 0", k, fifo_rd_en); end
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_rx(32);
    repeat (10) @(negedge clk);
    checks++;
    if (rx_d.size() != 32) begin errors++; $display("FAIL bp_count got %0d want 32", rx_d.size()); end
    for (int i = 0; i < 32 && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_q[i] || rx_l[i] !== ((i % PKT_LEN) == PKT_LEN - 1)) begin
        errors++;
        $display("FAIL bp_beat[%0d] got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_q[i],
                 ((i % PKT_LEN) == PKT_LEN - 1));
      end
    end
  endtask

  task automatic test_stop();
    int busy_cyc;
    do_reset();
    for (int i = 0; i < 32; i++) push_word(8'(8'h40 + i));
    enable = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 50 && rd_total < 4; k++) @(negedge clk);
    // Fifth read is visible now and issues on the coming edge
    while (fifo_rd_en !== 1'b1 && rd_total < 60) @(negedge clk);
    @(posedge clk); #1;
    enable = 1'b0;
    busy_cyc = -1;
    for (int k = 0; k < 100 && busy_cyc < 0; k++) begin
      @(negedge clk);
      if (busy === 1'b0) busy_cyc = cyc;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rd_total != 16) begin errors++; $display("FAIL stop_reads got %0d want 16", rd_total); end
    checks++;
    if (rx_d.size() != 16) begin errors++; $display("FAIL stop_count got %0d want 16", rx_d.size()); end
    for (int i = 0; i < 16 && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_q[i] || rx_l[i] !== ((i % PKT_LEN) == PKT_LEN - 1)) begin
        errors++;
        $display("FAIL stop_beat[%0d] got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_q[i],
                 ((i % PKT_LEN) == PKT_LEN - 1));
      end
    end
    checks++;
    if (rx_c.size() < 16 || busy_cyc != rx_c[15] + 1) begin
      errors++; $display("FAIL stop_busy_cycle got %0d want %0d", busy_cyc, rx_c.size() >= 16 ? rx_c[15] + 1 : -1);
    end
    checks++;
    if (wp - rp != 16) begin errors++; $display("FAIL stop_fifo_left got %0d want 16", wp - rp); end
  endtask

  task automatic test_empty_gaps();
    int pushed;
    do_reset();
    enable = 1'b1;
    pushed = 0;
    for (int c = 0; c < 130; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 0 && pushed < 40) begin
        push_word(8'($urandom));
        pushed++;
      end
      m_ready = (($urandom % 4) != 0);
    end
    m_ready = 1'b1;
    wait_rx(40);
    repeat (8) @(negedge clk);
    checks++;
    if (rx_d.size() != 40) begin errors++; $display("FAIL gap_count got %0d want 40", rx_d.size()); end
    for (int i = 0; i < 40 && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_q[i] || rx_l[i] !== ((i % PKT_LEN) == PKT_LEN - 1)) begin
        errors++;
        $display("FAIL gap_beat[%0d] got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_q[i],
                 ((i % PKT_LEN) == PKT_LEN - 1));
      end
    end
    checks++;
    if (illegal != 0) begin errors++; $display("FAIL rd_while_empty got %0d want 0", illegal); end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if (stat_pkts !== 16'd2) begin errors++; $display("FAIL gap_stat_pkts got %0d want 2", stat_pkts); end
`endif
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stop();
    test_empty_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
